twiddle_cmul_stage: RTL and testbench

- Consumer side of the 16-entry twiddle ROM for the 32-point MDC FFT.
- Sequences the ROM address per valid sample and reads back W = w_r + j·w_i (Q1.7, 128 = 1.0).
- Multiplies each streaming complex sample by W, then rounds and saturates back to data width.
- Sits between the butterfly stage output and the next commutator.

---
 rtl/twiddle_cmul_stage_pkg.sv | 26 ++
 rtl/twiddle_cmul_stage_cmul_round_sat.sv | 86 ++++++++
 rtl/twiddle_cmul_stage.sv | 79 +++++++
 tb/tb_twiddle_cmul_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/twiddle_cmul_stage_pkg.sv
// Shared constants for the 32-point MDC FFT twiddle multiply stage:
// default widths, rounding constant and saturation limits.
package twiddle_cmul_stage_pkg;

    localparam int DW_DEF   = 16;
    localparam int TW_DEF   = 9;
    localparam int FRAC_DEF = 7;
    localparam int ADDR_W   = 4;

    function automatic int rnd_const(input int frac);
        return 1 << (frac - 1);
    endfunction

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

    localparam int RND     = rnd_const(FRAC_DEF);
    localparam int SAT_MAX = sat_max(DW_DEF);
    localparam int SAT_MIN = sat_min(DW_DEF);

endpackage

// File: rtl/twiddle_cmul_stage_cmul_round_sat.sv
// Complex multiply back end: registered partial products (S2), then
// sum, round-half-up, saturate and register (S3).
module cmul_round_sat
    import twiddle_cmul_stage_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TW   = TW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 sof_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    input  logic signed [TW-1:0] wr_i,
    input  logic signed [TW-1:0] wi_i,
    output logic                 valid_o,
    output logic                 sof_o,
    output logic signed [DW-1:0] re_o,
    output logic signed [DW-1:0] im_o
);

    localparam int PW = DW + TW;
    localparam int SW = DW + TW + 1;
    localparam logic signed [SW-1:0] RND_C = SW'(rnd_const(FRAC));
    localparam logic signed [SW-1:0] SMAX  = SW'(sat_max(DW));
    localparam logic signed [SW-1:0] SMIN  = SW'(sat_min(DW));

    logic signed [PW-1:0] p_ar_q, p_bi_q, p_ai_q, p_br_q;
    logic signed [PW-1:0] p_ar_d, p_bi_d, p_ai_d, p_br_d;
    logic [1:0]           vld_pipe_q, sof_pipe_q;
    logic signed [DW-1:0] re_q, im_q, re_d, im_d;
    logic signed [SW-1:0] sum_re, sum_im, sh_re, sh_im;

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SMAX)      return SMAX[DW-1:0];
        else if (x < SMIN) return SMIN[DW-1:0];
        else               return x[DW-1:0];
    endfunction

    always_comb begin
        p_ar_d = PW'(a_i) * PW'(wr_i);
        p_bi_d = PW'(b_i) * PW'(wi_i);
        p_ai_d = PW'(a_i) * PW'(wi_i);
        p_br_d = PW'(b_i) * PW'(wr_i);
    end

    always_comb begin
        sum_re = SW'(p_ar_q) - SW'(p_bi_q);
        sum_im = SW'(p_ai_q) + SW'(p_br_q);
        sh_re  = (sum_re + RND_C) >>> FRAC;
        sh_im  = (sum_im + RND_C) >>> FRAC;
        // Idle output slots carry zero data, not stale products.
        re_d   = vld_pipe_q[0] ? sat(sh_re) : '0;
        im_d   = vld_pipe_q[0] ? sat(sh_im) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ar_q     <= '0;
            p_bi_q     <= '0;
            p_ai_q     <= '0;
            p_br_q     <= '0;
            vld_pipe_q <= '0;
            sof_pipe_q <= '0;
            re_q       <= '0;
            im_q       <= '0;
        end else begin
            p_ar_q     <= p_ar_d;
            p_bi_q     <= p_bi_d;
            p_ai_q     <= p_ai_d;
            p_br_q     <= p_br_d;
            vld_pipe_q <= {vld_pipe_q[0], valid_i};
            sof_pipe_q <= {sof_pipe_q[0], sof_i & valid_i};
            re_q       <= re_d;
            im_q       <= im_d;
        end
    end

    assign valid_o = vld_pipe_q[1];
    assign sof_o   = sof_pipe_q[1];
    assign re_o    = re_q;
    assign im_o    = im_q;

endmodule

// File: rtl/twiddle_cmul_stage.sv
// Twiddle ROM sequencer and framing check; samples are captured with their
// twiddle (S1) and handed to the complex multiply back end.
module twiddle_cmul_stage
    import twiddle_cmul_stage_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TW   = TW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic signed [TW-1:0] w_r,
    input  logic signed [TW-1:0] w_i,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 frame_err
);

    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 frame_err_q, frame_err_d;
    logic                 vld_q, sof_q;
    logic signed [DW-1:0] a_q, b_q;
    logic signed [TW-1:0] wr_q, wi_q;

    // sof realigns the index even while the counter is mid-frame.
    assign rom_addr = in_sof ? '0 : cnt_q;

    always_comb begin
        cnt_d       = in_valid ? rom_addr + 1'b1 : cnt_q;
        frame_err_d = frame_err_q | (in_valid & in_sof & (cnt_q != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            vld_q       <= 1'b0;
            sof_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            wr_q        <= '0;
            wi_q        <= '0;
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            vld_q       <= in_valid;
            sof_q       <= in_sof;
            a_q         <= in_re;
            b_q         <= in_im;
            wr_q        <= w_r;
            wi_q        <= w_i;
        end
    end

    cmul_round_sat #(.DW(DW), .TW(TW), .FRAC(FRAC)) u_cmul (
        .clk     (clk),
        .rst     (rst),
        .valid_i (vld_q),
        .sof_i   (sof_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .wr_i    (wr_q),
        .wi_i    (wi_q),
        .valid_o (out_valid),
        .sof_o   (out_sof),
        .re_o    (out_re),
        .im_o    (out_im)
    );

    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_twiddle_cmul_stage.sv
// Randomized + directed bench for twiddle_cmul_stage against a
// complex-arithmetic reference model with a 3-cycle output schedule.
module tb_twiddle_cmul_stage;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0, in_sof = 1'b0;
    logic signed [15:0] in_re = '0, in_im = '0;
    logic [3:0]        rom_addr;
    logic signed [8:0] w_r, w_i;
    logic              out_valid, out_sof, frame_err;
    logic signed [15:0] out_re, out_im;

    int n_vec = 0, n_bad = 0;

    // W_k = 128*exp(-j*2*pi*k/32), truncated toward zero
    int wr_tab[16] = '{128, 125, 118, 106, 90, 71, 48, 24,
                       0, -24, -48, -71, -90, -106, -118, -125};
    int wi_tab[16] = '{0, -24, -48, -71, -90, -106, -118, -125,
                       -128, -125, -118, -106, -90, -71, -48, -24};

    always_comb begin
        w_r = 9'(wr_tab[rom_addr]);
        w_i = 9'(wi_tab[rom_addr]);
    end

    always #5 clk = ~clk;

    twiddle_cmul_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .rom_addr(rom_addr),
        .w_r(w_r), .w_i(w_i), .out_valid(out_valid), .out_sof(out_sof),
        .out_re(out_re), .out_im(out_im), .frame_err(frame_err)
    );

    typedef struct { bit v; bit s; int re; int im; } ent_t;
    ent_t pipe[3];
    int   m_idx = 0;
    bit   m_err = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // (x + 64) / 128 with floor, then clamp to 16-bit signed
    function automatic int rnd_sat(input longint x);
        longint y, q;
        y = x + 64;
        q = (y >= 0) ? y / 128 : -((-y + 127) / 128);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_idx = 0;
        m_err = 0;
    endtask

    // One clock: drive, check combinational address and current outputs, advance.
    task automatic cyc(input bit v, input bit s, input int a, input int b);
        int k;
        ent_t e;
        in_valid = v; in_sof = s;
        in_re = 16'(a); in_im = 16'(b);
        #3;
        k = s ? 0 : m_idx;
        chk("rom_addr", int'(rom_addr), k);
        chk("out_valid", int'(out_valid), int'(pipe[2].v));
        chk("out_sof", int'(out_sof), int'(pipe[2].s));
        chk("out_re", int'(out_re), pipe[2].re);
        chk("out_im", int'(out_im), pipe[2].im);
        chk("frame_err", int'(frame_err), int'(m_err));
        e = '{0, 0, 0, 0};
        if (v) begin
            e.v  = 1;
            e.s  = s;
            e.re = rnd_sat(longint'(a) * wr_tab[k] - longint'(b) * wi_tab[k]);
            e.im = rnd_sat(longint'(a) * wi_tab[k] + longint'(b) * wr_tab[k]);
            if (s && m_idx != 0) m_err = 1;
            m_idx = (k + 1) % 16;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    function automatic int rnd_data();
        case ($urandom_range(0, 5))
            0: return -32768;
            1: return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        clear_model();
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_re", int'(out_re), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // identity, quarter-turn, 45 degrees, saturation
        cyc(1, 1, 1000, -500);
        for (int i = 1; i < 16; i++) begin
            if (i == 4)      cyc(1, 0, 100, 0);
            else if (i == 8) cyc(1, 0, 1000, -500);
            else             cyc(1, 0, rnd_data(), rnd_data());
        end
        cyc(1, 1, 0, 0);
        for (int i = 1; i < 16; i++) begin
            if (i == 8) cyc(1, 0, -32768, -32768);
            else        cyc(1, 0, rnd_data(), rnd_data());
        end
        idle(4);

        // gaps and wrap: 20 samples on alternate cycles
        for (int i = 0; i < 20; i++) begin
            cyc(1, i == 0, rnd_data(), rnd_data());
            cyc(0, 0, 0, 0);
        end
        idle(4);

        // sof with valid low is ignored; then misaligned sof at index 5
        cyc(1, 1, 10, 20);
        cyc(0, 1, 0, 0);
        for (int i = 1; i < 5; i++) cyc(1, 0, rnd_data(), rnd_data());
        cyc(1, 1, 300, -300);
        for (int i = 0; i < 6; i++) cyc(1, 0, rnd_data(), rnd_data());

        // asynchronous reset mid-stream
        in_valid = 1; in_sof = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_err", int'(frame_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        idle(2);

        // random traffic, mostly well framed
        for (int i = 0; i < 400; i++) begin
            bit v, s;
            v = ($urandom_range(0, 9) < 7);
            s = (m_idx == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            cyc(v, s, rnd_data(), rnd_data());
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
